// File: rtl/pixel_frame_buffer.sv
// True dual-port pixel memory: port A is an Avalon-MM slave with byte lanes and clock enable,
// port B is a scan-out engine that streams a pixel run through a 4-entry FIFO onto Avalon-ST.
module pixel_frame_buffer #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 13,
    parameter int    OUT_REG    = 0,
    parameter string INIT_FILE  = "pixelmemory.hex"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_WIDTH-1:0] s1_writedata,
    output logic [DATA_WIDTH-1:0] s1_readdata,
    output logic                  s1_readdatavalid,
    input  logic                  clken,
    input  logic                  scan_start,
    input  logic [ADDR_WIDTH-1:0] scan_base,
    input  logic [ADDR_WIDTH:0]   scan_len,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  src_sop,
    output logic                  src_eop
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int EW    = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q_a, q_b;
    logic                  wr_a, rd_a;
    logic                  rd_b, sop_b, eop_b;
    logic [ADDR_WIDTH-1:0] addr_b, addr_reg;
    logic [ADDR_WIDTH:0]   left_reg;
    logic                  done_reg;
    logic                  a_v1_reg, a_v_last;
    logic [DATA_WIDTH-1:0] a_d_last;
    logic                  b_v1_reg, land_v;
    logic [1:0]            b_f1_reg;
    logic [EW-1:0]         land_e, head;
    logic [2:0]            inflight, count_reg;
    logic [EW-1:0]         fifo_mem [4];
    logic [1:0]            wr_ptr_reg, rd_ptr_reg;
    logic                  push, pop, credit_ok;

    assign wr_a = s1_chipselect & s1_write & clken;
    assign rd_a = s1_chipselect & s1_read & ~s1_write & clken;

    // Both read ports see the pre-write contents when colliding with a port A write.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            for (int i = 0; i < LANES; i++) begin
                if (s1_byteenable[i])
                    mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
            end
        end
        if (clken)
            q_a <= mem[s1_address];
        if (rd_b)
            q_b <= mem[addr_b];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   a_v1_reg <= 1'b0;
        else if (clken) a_v1_reg <= rd_a;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_v1_reg <= 1'b0;
            b_f1_reg <= 2'b00;
        end else begin
            b_v1_reg <= rd_b;
            b_f1_reg <= {sop_b, eop_b};
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  a_v2_reg, b_v2_reg;
            logic [DATA_WIDTH-1:0] a_d2_reg;
            logic [EW-1:0]         b_e2_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_v2_reg <= 1'b0;
                    a_d2_reg <= '0;
                    b_v2_reg <= 1'b0;
                    b_e2_reg <= '0;
                end else begin
                    if (clken) begin
                        a_v2_reg <= a_v1_reg;
                        a_d2_reg <= q_a;
                    end
                    b_v2_reg <= b_v1_reg;
                    b_e2_reg <= {b_f1_reg, q_b};
                end
            end
            assign a_v_last = a_v2_reg;
            assign a_d_last = a_d2_reg;
            assign land_v   = b_v2_reg;
            assign land_e   = b_e2_reg;
            assign inflight = {2'b00, b_v1_reg} + {2'b00, b_v2_reg};
        end else begin : g_no_out_reg
            assign a_v_last = a_v1_reg;
            assign a_d_last = q_a;
            assign land_v   = b_v1_reg;
            assign land_e   = {b_f1_reg, q_b};
            assign inflight = {2'b00, b_v1_reg};
        end
    endgenerate

    // A stalled clken freezes the pipeline and masks the valid strobe until it returns.
    assign s1_readdatavalid = a_v_last & clken;
    assign s1_readdata      = s1_readdatavalid ? a_d_last : '0;

    assign push = land_v;
    assign pop  = src_valid & src_ready;
    assign head = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= land_e;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
        end
    end

    assign src_valid = (count_reg != 3'd0);
    assign src_data  = src_valid ? head[DATA_WIDTH-1:0] : '0;
    assign src_sop   = src_valid & head[EW-1];
    assign src_eop   = src_valid & head[EW-2];

    // Every issued read reserves a FIFO slot, so backpressure can never overflow it.
    assign credit_ok = ({1'b0, inflight} + {1'b0, count_reg}) < 4'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (scan_start && scan_len != '0)
                         state_next = (scan_len == LEN_ONE) ? DRAIN : RUN;
            RUN:     if (credit_ok && left_reg == LEN_ONE) state_next = DRAIN;
            DRAIN:   if (pop && src_eop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The first read is issued straight from IDLE to reach the two-cycle first-beat latency.
    always_comb begin
        rd_b   = 1'b0;
        addr_b = addr_reg;
        sop_b  = 1'b0;
        eop_b  = 1'b0;
        case (state_reg)
            IDLE: if (scan_start && scan_len != '0) begin
                rd_b   = 1'b1;
                addr_b = scan_base;
                sop_b  = 1'b1;
                eop_b  = (scan_len == LEN_ONE);
            end
            RUN: if (credit_ok) begin
                rd_b  = 1'b1;
                eop_b = (left_reg == LEN_ONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg <= '0;
            left_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == IDLE && scan_start && scan_len == '0) ||
                        (state_reg == DRAIN && pop && src_eop);
            if (rd_b) begin
                addr_reg <= addr_b + ADDR_ONE;
                left_reg <= ((state_reg == IDLE) ? scan_len : left_reg) - LEN_ONE;
            end
        end
    end

    assign scan_busy = (state_reg != IDLE);
    assign scan_done = done_reg;
endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer: table-driven port A byte-lane vectors plus
// hand-written scan, backpressure, wrap, clken and mid-scan reset sequences.
module tb_pixel_frame_buffer;
    localparam int DW   = 32;
    localparam int AW   = 13;
    localparam int OREG = 0;
    localparam int LAT  = 1 + OREG;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] s1_address;
    logic [3:0]    s1_byteenable;
    logic          s1_chipselect, s1_read, s1_write;
    logic [DW-1:0] s1_writedata, s1_readdata;
    logic          s1_readdatavalid, clken;
    logic          scan_start;
    logic [AW-1:0] scan_base;
    logic [AW:0]   scan_len;
    logic          scan_busy, scan_done;
    logic [DW-1:0] src_data;
    logic          src_valid, src_ready, src_sop, src_eop;

    pixel_frame_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(OREG)) dut (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable),
        .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid), .clken(clken),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sop(src_sop), .src_eop(src_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %s = 0x%0h", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = a;
        s1_byteenable = be;   s1_writedata = d;
        @(posedge clk); #1;
        s1_chipselect = 1'b0; s1_write = 1'b0; s1_byteenable = '0;
    endtask

    task automatic read_a(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = a;
        @(posedge clk); #1;
        s1_chipselect = 1'b0; s1_read = 1'b0;
        lat = 0; d = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (s1_readdatavalid) begin
                lat = i; d = s1_readdata;
                break;
            end
        end
    endtask

    logic [DW-1:0] bq_data[$];
    bit            bq_sop[$];
    bit            bq_eop[$];
    int            done_cnt, done_idx, first_idx, stall_bad;
    logic          busy_after, busy_first;

    // mode 0: ready always high; mode 1: ready toggling plus a 10-cycle stall;
    // mode 2: ready high, with a port A write and a second scan_start while busy.
    task automatic scan(input logic [AW-1:0] base, input logic [AW:0] len, input int mode);
        bit          held;
        logic [33:0] held_v;
        bq_data.delete(); bq_sop.delete(); bq_eop.delete();
        done_cnt = 0; done_idx = -1; first_idx = -1; stall_bad = 0; held = 0; held_v = '0;
        busy_first = 1'b0;
        scan_base = base; scan_len = len; scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        for (int idx = 1; idx <= 300; idx++) begin
            if (mode == 1) src_ready = (idx % 2 == 0) && !(idx >= 6 && idx < 16);
            else           src_ready = 1'b1;
            if (mode == 2 && idx == 2) begin
                scan_start = 1'b1; scan_base = '0; scan_len = 3;
                s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 300;
                s1_byteenable = 4'hF; s1_writedata = 32'hCAFE0300;
            end
            if (mode == 2 && idx == 3) begin
                scan_start = 1'b0; s1_chipselect = 1'b0; s1_write = 1'b0;
            end
            @(negedge clk);
            if (idx == 1) busy_first = scan_busy;
            if (src_valid && first_idx < 0) first_idx = idx;
            if (held && {src_sop, src_eop, src_data} !== held_v) stall_bad++;
            held   = src_valid && !src_ready;
            held_v = {src_sop, src_eop, src_data};
            if (src_valid && src_ready) begin
                bq_data.push_back(src_data);
                bq_sop.push_back(src_sop);
                bq_eop.push_back(src_eop);
            end
            if (scan_done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            if (done_idx >= 0 && idx >= done_idx + 3) break;
            @(posedge clk); #1;
        end
        busy_after = scan_busy;
        @(posedge clk); #1;
        src_ready = 1'b0;
        $display("scan base=%0d len=%0d mode=%0d: %0d beats, done=%0d, first valid cycle %0d",
                 base, len, mode, bq_data.size(), done_cnt, first_idx);
    endtask

    task automatic check_run(input string tag, input int n, input logic [DW-1:0] v0,
                             input logic [DW-1:0] stride);
        logic [DW-1:0] e;
        check({tag, "_count"}, bq_data.size(), n);
        for (int i = 0; i < bq_data.size() && i < n; i++) begin
            e = v0 + stride * i;
            check($sformatf("%s_data%0d", tag, i), bq_data[i], e);
            check($sformatf("%s_sop%0d", tag, i), bq_sop[i], (i == 0));
            check($sformatf("%s_eop%0d", tag, i), bq_eop[i], (i == n - 1));
        end
        check({tag, "_busy_start"}, busy_first, 1'b1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_after"}, busy_after, 1'b0);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } avec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        avec_t         vecs [7];
        logic [DW-1:0] d;
        int            lat, bad, n;

        vecs[0] = '{13'd5,    4'hF, 32'hAABBCCDD, 32'hAABBCCDD};
        vecs[1] = '{13'd5,    4'h2, 32'h11223344, 32'hAABB33DD};
        vecs[2] = '{13'd6,    4'hF, 32'h01020304, 32'h01020304};
        vecs[3] = '{13'd6,    4'h9, 32'hF0E0D0C0, 32'hF00203C0};
        vecs[4] = '{13'd8191, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5] = '{13'd0,    4'hF, 32'h00000000, 32'h00000000};
        vecs[6] = '{13'd0,    4'h4, 32'h12345678, 32'h00340000};

        reset_n = 1'b0; s1_address = '0; s1_byteenable = '0; s1_chipselect = 1'b0;
        s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0; clken = 1'b1;
        scan_start = 1'b0; scan_base = '0; scan_len = '0; src_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_st_outputs", {src_valid, src_sop, src_eop, scan_busy, scan_done, src_data}, '0);
        check("rst_a_outputs", {s1_readdatavalid, s1_readdata}, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            write_a(vecs[i].addr, vecs[i].be, vecs[i].wdata);
            read_a(vecs[i].addr, d, lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, LAT);
        end

        clken = 1'b0;
        write_a(13'd5, 4'hF, 32'h0BADF00D);
        clken = 1'b1;
        read_a(13'd5, d, lat);
        check("clken_write_ignored", d, 32'hAABB33DD);

        s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 13'd6;
        @(posedge clk); #1;
        s1_chipselect = 1'b0; s1_read = 1'b0; clken = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (s1_readdatavalid) bad++;
        end
        check("clken_rdv_held_low", bad, 0);
        clken = 1'b1;
        lat = 0; d = '0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (s1_readdatavalid) begin
                lat = i; d = s1_readdata;
                break;
            end
            @(negedge clk);
        end
        check("clken_resume_latency", lat, LAT);
        check("clken_resume_data", d, 32'hF00203C0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) write_a(AW'(i), 4'hF, 32'(i * 3));
        scan(13'd2, 14'd4, 0);
        check("basic_first_latency", first_idx, 2 + OREG);
        check_run("basic", 4, 32'd6, 32'd3);

        for (int i = 0; i < 16; i++) write_a(AW'(100 + i), 4'hF, 32'h1000 + i);
        scan(13'd100, 14'd16, 1);
        check("bp_stall_stable", stall_bad, 0);
        check_run("bp", 16, 32'h1000, 32'd1);

        write_a(13'd8190, 4'hF, 32'h5A5A0001);
        write_a(13'd8191, 4'hF, 32'h5A5A0002);
        write_a(13'd0,    4'hF, 32'h5A5A0003);
        write_a(13'd1,    4'hF, 32'h5A5A0004);
        scan(13'd8190, 14'd4, 0);
        check_run("wrap", 4, 32'h5A5A0001, 32'd1);

        scan(13'd5, 14'd0, 0);
        check("len0_beats", bq_data.size(), 0);
        check("len0_no_valid", first_idx, -1);
        check("len0_done_cnt", done_cnt, 1);
        check("len0_done_cycle", done_idx, 1);

        scan(13'd3, 14'd1, 0);
        check_run("len1", 1, 32'd9, 32'd0);

        for (int i = 0; i < 8; i++) write_a(AW'(200 + i), 4'hF, 32'h2000 + i);
        scan(13'd200, 14'd8, 2);
        check_run("conc", 8, 32'h2000, 32'd1);
        read_a(13'd300, d, lat);
        check("conc_porta_write", d, 32'hCAFE0300);
        @(posedge clk); #1;

        scan_base = 13'd100; scan_len = 14'd10; scan_start = 1'b1; src_ready = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (src_valid && src_ready) n++;
        end
        check("rstmid_beats_before", n, 3);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_st_outputs", {src_valid, src_sop, src_eop, scan_busy, scan_done, src_data}, '0);
        check("rstmid_a_outputs", {s1_readdatavalid, s1_readdata}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (scan_done || src_valid || scan_busy) bad++;
        end
        check("rstmid_quiet_after", bad, 0);
        @(posedge clk); #1;
        scan(13'd104, 14'd2, 0);
        check_run("rstmid_fresh", 2, 32'h1004, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
